// File: rtl/axi4_lite_init_sequencer.sv
// AXI4-Lite init sequencer: after a start pulse it writes each (address, data)
// entry of a parameter table through a single-outstanding AXI4-Lite master port.
// When VERIFY is set, it reads each entry back and compares it. Busy, done and
// error status are reported, together with the index of the failing entry.
module axi4_lite_init_sequencer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = 4,
    parameter logic [NUM_ENTRIES*ADDR_WIDTH-1:0] INIT_ADDR =
        {32'h0C, 32'h08, 32'h04, 32'h00},
    parameter logic [NUM_ENTRIES*DATA_WIDTH-1:0] INIT_DATA =
        {32'hCAFEF00D, 32'h12345678, 32'h5A5A5A5A, 32'hA5A5A5A5},
    parameter bit VERIFY  = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [3:0]              err_index,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE
    } state_t;

    localparam logic [7:0] LP_TMO  = 8'(TIMEOUT);
    localparam logic [3:0] LP_LAST = 4'(NUM_ENTRIES - 1);

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_idx, w_idx_nxt;
    logic [7:0]              r_cnt;
    logic                    r_aw_done, r_w_done;
    logic                    r_error;
    logic [1:0]              r_err_code;
    logic [3:0]              r_err_index;
    logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_wait, w_tmo;
    logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                    w_next, w_err_set, w_start_acc;
    logic [1:0]              w_err_code;

    function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [3:0] idx);
        return INIT_ADDR[idx*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_data(input logic [3:0] idx);
        return INIT_DATA[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Any state that waits on the slave is subject to the timeout.
    assign w_wait = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
    assign w_tmo  = w_wait && (r_cnt == LP_TMO);

    // On timeout every VALID/READY is masked in the same cycle, so no late handshake can slip in.
    assign AWVALID = (r_state == S_WR_REQ) && !r_aw_done && !w_tmo;
    assign WVALID  = (r_state == S_WR_REQ) && !r_w_done && !w_tmo;
    assign BREADY  = (r_state == S_WR_RESP) && !w_tmo;
    assign ARVALID = (r_state == S_RD_REQ) && !w_tmo;
    assign RREADY  = (r_state == S_RD_DATA) && !w_tmo;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_b_hs  = BREADY && BVALID;
    assign w_ar_hs = ARVALID && ARREADY;
    assign w_r_hs  = RREADY && RVALID;

    assign AWADDR    = r_awaddr;
    assign WDATA     = r_wdata;
    assign WSTRB     = '1;
    assign ARADDR    = r_araddr;
    assign busy      = w_wait;
    assign done      = (r_state == S_DONE);
    assign error     = r_error;
    assign err_code  = r_err_code;
    assign err_index = r_err_index;

    // Next-state, next-index and error-exit decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_next      = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = 2'b00;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_WR_REQ;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_WR_REQ: begin
                if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_err_code = 2'b11;
                end else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_err_code = 2'b11;
                end else if (w_b_hs) begin
                    if (BRESP != 2'b00) begin
                        w_err_set  = 1'b1;
                        w_err_code = 2'b01;
                    end else if (VERIFY) begin
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_next = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_err_code = 2'b11;
                end else if (w_ar_hs) begin
                    w_state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_err_code = 2'b11;
                end else if (w_r_hs) begin
                    if (RRESP != 2'b00) begin
                        w_err_set  = 1'b1;
                        w_err_code = 2'b01;
                    end else if (RDATA != f_data(r_idx)) begin
                        w_err_set  = 1'b1;
                        w_err_code = 2'b10;
                    end else begin
                        w_next = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_next) begin
            if (r_idx == LP_LAST) begin
                w_state_nxt = S_DONE;
            end else begin
                w_idx_nxt   = r_idx + 4'd1;
                w_state_nxt = S_WR_REQ;
            end
        end
        if (w_err_set) begin
            w_state_nxt = S_DONE;
        end
    end

    // State and entry-index registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Per-state wait counter and per-channel write handshake flags; both restart on every state change.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt     <= 8'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_cnt     <= 8'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_wait) r_cnt <= r_cnt + 8'd1;
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs) r_w_done <= 1'b1;
        end
    end

    // Error status: cleared on an accepted start, latched on the error exit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_index <= 4'd0;
        end else if (w_start_acc) begin
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_index <= 4'd0;
        end else if (w_err_set) begin
            r_error     <= 1'b1;
            r_err_code  <= w_err_code;
            r_err_index <= r_idx;
        end
    end

    // Channel payloads load on state entry, so they stay stable while VALID waits for READY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_araddr <= '0;
        end else begin
            if ((w_state_nxt == S_WR_REQ) && (r_state != S_WR_REQ)) begin
                r_awaddr <= f_addr(w_idx_nxt);
                r_wdata  <= f_data(w_idx_nxt);
            end
            if ((w_state_nxt == S_RD_REQ) && (r_state != S_RD_REQ)) begin
                r_araddr <= f_addr(r_idx);
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_init_sequencer.sv
// Bench for axi4_lite_init_sequencer: a reactive AXI4-Lite slave with
// randomized wait states and injectable faults. The expected end state of each
// run comes from a table-walk model of the sequencer.
module tb_axi4_lite_init_sequencer;

    logic        ACLK, ARESET, start;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [3:0]  err_index;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    axi4_lite_init_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_index(err_index),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] TA [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] TD [4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'hCAFEF00D};

    // slave configuration: fixed wait (>=0) or random (-1); fault entry or -1
    int fix_aw, fix_w, fix_b, fix_ar, fix_r;
    int f_bresp, f_rdata, f_nob;

    // slave observation logs
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] mem [logic [31:0]];
    int b_cnt, r_cnt, aw_cyc, w_cyc, ar_cyc, bready_cyc;
    int proto_err, stab_err, strb_err;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0] aw_prev, w_prev, ar_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(0, 3));
    endfunction

    task automatic clear_logs();
        aw_q.delete(); w_q.delete(); ar_q.delete(); mem.delete();
        b_cnt = 0; r_cnt = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; bready_cyc = 0;
        proto_err = 0; stab_err = 0; strb_err = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    endtask

    task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input int fb, input int fr, input int fn);
        fix_aw = aw; fix_w = w; fix_b = b; fix_ar = ar; fix_r = r;
        f_bresp = fb; f_rdata = fr; f_nob = fn;
    endtask

    // Reference: walk the table; each entry is a write, then a read-back, unless a fault ends the walk.
    task automatic model(output int ec, output int ei, output int nw, output int nr);
        ec = 0; ei = 0; nw = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
            nw++;
            if (f_nob == i)   begin ec = 3; ei = i; break; end
            if (f_bresp == i) begin ec = 1; ei = i; break; end
            nr++;
            if (f_rdata == i) begin ec = 2; ei = i; break; end
        end
    endtask

    // Reactive slave: decides READY/VALID at each falling edge for the next rising edge.
    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (AWVALID) begin
                    aw_cyc++;
                    if (aw_wait == 0) aw_dly = pick(fix_aw);
                    else if (AWADDR != aw_prev) stab_err++;
                    aw_prev = AWADDR;
                    if (aw_wait >= aw_dly) begin
                        AWREADY = 1; aw_q.push_back(AWADDR); aw_wait = 0;
                    end else begin
                        AWREADY = 0; aw_wait++;
                    end
                end else begin
                    AWREADY = 0; aw_wait = 0;
                end

                if (WVALID) begin
                    w_cyc++;
                    if (WSTRB != 4'hF) strb_err++;
                    if (w_wait == 0) w_dly = pick(fix_w);
                    else if (WDATA != w_prev) stab_err++;
                    w_prev = WDATA;
                    if (w_wait >= w_dly) begin
                        WREADY = 1; w_q.push_back(WDATA); w_wait = 0;
                    end else begin
                        WREADY = 0; w_wait++;
                    end
                end else begin
                    WREADY = 0; w_wait = 0;
                end

                if (BREADY) begin
                    bready_cyc++;
                    if (aw_q.size() != b_cnt + 1 || w_q.size() != b_cnt + 1) proto_err++;
                    if (b_wait == 0) b_dly = pick(fix_b);
                    if (b_cnt != f_nob && b_wait >= b_dly && aw_q.size() > b_cnt && w_q.size() > b_cnt) begin
                        BVALID = 1;
                        BRESP  = (b_cnt == f_bresp) ? 2'b10 : 2'b00;
                        if (BRESP == 2'b00) mem[aw_q[b_cnt]] = w_q[b_cnt];
                        b_cnt++; b_wait = 0;
                    end else begin
                        BVALID = 0; BRESP = 2'($urandom); b_wait++;
                    end
                end else begin
                    BVALID = 0; BRESP = 2'($urandom); b_wait = 0;
                end

                if (ARVALID) begin
                    ar_cyc++;
                    if (ar_q.size() + 1 != b_cnt) proto_err++;
                    if (ar_wait == 0) ar_dly = pick(fix_ar);
                    else if (ARADDR != ar_prev) stab_err++;
                    ar_prev = ARADDR;
                    if (ar_wait >= ar_dly) begin
                        ARREADY = 1; ar_q.push_back(ARADDR); ar_wait = 0;
                    end else begin
                        ARREADY = 0; ar_wait++;
                    end
                end else begin
                    ARREADY = 0; ar_wait = 0;
                end

                if (RREADY) begin
                    if (r_cnt + 1 != ar_q.size()) proto_err++;
                    if (r_wait == 0) r_dly = pick(fix_r);
                    if (r_wait >= r_dly && ar_q.size() > r_cnt) begin
                        RVALID = 1; RRESP = 2'b00;
                        if (r_cnt == f_rdata) RDATA = 32'h0BAD0BAD;
                        else if (mem.exists(ar_q[r_cnt])) RDATA = mem[ar_q[r_cnt]];
                        else RDATA = 32'hDEADBEEF;
                        r_cnt++; r_wait = 0;
                    end else begin
                        RVALID = 0; RDATA = $urandom; RRESP = 2'($urandom); r_wait++;
                    end
                end else begin
                    RVALID = 0; RDATA = $urandom; RRESP = 2'($urandom); r_wait = 0;
                end
            end
        end
    end

    task automatic do_run(input string tag, input bit poke);
        int ec, ei, nw, nr;
        bit got;
        clear_logs();
        @(negedge ACLK); start = 1;
        @(negedge ACLK); start = 0;
        chk({tag, "_busy_done_after_start"}, {busy, done}, 2'b10);
        if (poke) begin
            @(negedge ACLK);
            if (busy) begin
                start = 1;
                @(negedge ACLK); start = 0;
            end
        end
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin got = 1; break; end
            @(negedge ACLK);
        end
        chk({tag, "_reach_done"}, got, 1);
        model(ec, ei, nw, nr);
        chk({tag, "_error"}, error, (ec != 0));
        chk({tag, "_err_code"}, err_code, ec);
        chk({tag, "_err_index"}, err_index, ei);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_chan_idle"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        chk({tag, "_n_aw"}, aw_q.size(), nw);
        chk({tag, "_n_w"}, w_q.size(), nw);
        chk({tag, "_n_ar"}, ar_q.size(), nr);
        for (int k = 0; k < nw && k < aw_q.size(); k++) chk({tag, "_awaddr"}, aw_q[k], TA[k]);
        for (int k = 0; k < nw && k < w_q.size(); k++)  chk({tag, "_wdata"}, w_q[k], TD[k]);
        for (int k = 0; k < nr && k < ar_q.size(); k++) chk({tag, "_araddr"}, ar_q[k], TA[k]);
        chk({tag, "_protocol"}, proto_err + stab_err + strb_err, 0);
    endtask

    initial begin
        bit found;
        ARESET = 1; start = 0;
        set_cfg(0, 0, 0, 0, 0, -1, -1, -1);
        clear_logs();
        repeat (2) @(negedge ACLK);
        chk("rst_status", {busy, done, error, err_code, err_index}, 0);
        chk("rst_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_wstrb", WSTRB, 4'hF);
        ARESET = 0;
        repeat (2) @(negedge ACLK);

        set_cfg(0, 0, 0, 0, 0, -1, -1, -1);
        do_run("zero_wait", 0);
        chk("zero_wait_aw_cycles", aw_cyc, 4);
        chk("zero_wait_w_cycles", w_cyc, 4);

        set_cfg(3, 0, 0, 0, 0, -1, -1, -1);
        do_run("aw_delay3", 0);
        chk("aw_delay3_aw_cycles", aw_cyc, 16);
        chk("aw_delay3_w_cycles", w_cyc, 4);

        set_cfg(0, 0, 0, 0, 0, 2, -1, -1);
        do_run("bresp_e2", 0);

        set_cfg(-1, -1, -1, -1, -1, -1, 1, -1);
        do_run("rdata_e1", 0);

        set_cfg(-1, -1, -1, -1, -1, -1, -1, 0);
        do_run("timeout_e0", 0);
        chk("timeout_bready_cycles", bready_cyc, 255);

        for (int it = 0; it < 6; it++) begin
            int ft, fi;
            ft = $urandom_range(0, 3);
            fi = $urandom_range(0, 3);
            set_cfg(-1, -1, -1, -1, -1,
                    (ft == 1) ? fi : -1, (ft == 2) ? fi : -1, (ft == 3) ? fi : -1);
            do_run($sformatf("rand%0d", it), 1);
        end

        // reset in the middle of entry 1 write request
        set_cfg(6, 6, 0, 0, 0, -1, -1, -1);
        clear_logs();
        @(negedge ACLK); start = 1;
        @(negedge ACLK); start = 0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (AWVALID && AWADDR == 32'h4) begin found = 1; break; end
        end
        chk("midrst_reached_entry1", found, 1);
        @(negedge ACLK);
        #2 ARESET = 1;
        #1;
        chk("midrst_status", {busy, done, error, err_code, err_index}, 0);
        chk("midrst_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        chk("midrst_payload", {AWADDR, WDATA}, 0);
        chk("midrst_araddr", ARADDR, 0);
        @(negedge ACLK);
        @(negedge ACLK); ARESET = 0;
        clear_logs();
        repeat (5) @(negedge ACLK);
        chk("midrst_no_traffic", aw_cyc + w_cyc + ar_cyc + bready_cyc, 0);
        chk("midrst_idle_status", {busy, done}, 0);

        set_cfg(-1, -1, -1, -1, -1, -1, -1, -1);
        do_run("post_reset", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_init_sequencer.md
Name: axi4_lite_init_sequencer

Overview:
AXI4-Lite master-side controller that configures an axi4_lite_slave register bank after reset or on request. On a start pulse it walks a parameter-defined table of (address, data) entries, issuing one AXI4-Lite write per entry. When VERIFY=1 it reads each entry back and compares. It sits between system bring-up logic and the slave's AW/W/B/AR/R channels, and reports busy/done/error status with the failing entry index.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (WSTRB width = DATA_WIDTH/8)
NUM_ENTRIES, 4, table depth (1..16)
INIT_ADDR, {32'h0C,32'h08,32'h04,32'h00}, packed table addresses; entry i at [i*ADDR_WIDTH +: ADDR_WIDTH]
INIT_DATA, {32'hCAFEF00D,32'h12345678,32'h5A5A5A5A,32'hA5A5A5A5}, packed table data; entry i at [i*DATA_WIDTH +: DATA_WIDTH]
VERIFY, 1, 1 = read back and compare each entry after writing it
TIMEOUT, 255, maximum cycles to wait in any handshake state (8-bit counter)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; honoured only in IDLE/DONE
busy  out  1  high from the cycle after start until DONE is entered
done  out  1  level; high in DONE until next accepted start
error  out  1  level; valid while done=1
err_code  out  2  00 none, 01 BRESP/RRESP not OKAY, 10 readback mismatch, 11 timeout
err_index  out  4  index of the failing entry
AWADDR/AWVALID  out  ADDR_WIDTH/1  write address channel
AWREADY  in  1  write address ready
WDATA/WSTRB/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel; WSTRB is always all-ones
WREADY  in  1  write data ready
BRESP/BVALID  in  2/1  write response
BREADY  out  1  write response ready
ARADDR/ARVALID  out  ADDR_WIDTH/1  read address channel
ARREADY  in  1  read address ready
RDATA/RRESP/RVALID  in  DATA_WIDTH/2/1  read data channel
RREADY  out  1  read data ready

Behaviour:
- Reset (asynchronous, immediate): all VALID/READY outputs 0; AWADDR, WDATA, ARADDR 0; WSTRB all-ones; busy, done, error 0; err_code 0; err_index 0; FSM in IDLE; entry index 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE/DONE + start at a posedge: clear done, error, err_code and the index; go to WR_REQ. AWVALID, WVALID and busy assert on the next cycle with entry 0.
- WR_REQ: AWVALID and WVALID are asserted together and not conditioned on READY. Each drops on the cycle after its own handshake (VALID&READY at a posedge); payload stays stable until then. After both handshakes complete, in either order or the same cycle, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID: BREADY drops. If BRESP!=00, take the error exit with code 01. Otherwise go to RD_REQ if VERIFY, else go to NEXT.
- RD_REQ: ARVALID=1 with ARADDR = entry address, held until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID: if RRESP!=00, error 01. Else if RDATA!=entry data, error 10. Else go to NEXT.
- NEXT (same edge as the completing handshake): if index==NUM_ENTRIES-1, go to DONE with error=0. Otherwise increment the index and return to WR_REQ, so the next AWVALID/WVALID assert the following cycle.
- Error exit: error=1, err_code set, err_index = current index; go to DONE. Remaining entries are skipped.
- Timeout: the counter clears on every state entry and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA. When it reaches TIMEOUT, take the error exit with code 11. All VALID/READY outputs drop in that same cycle.
- DONE: busy=0, done=1, all channel VALID/READY outputs 0.
- start while busy is ignored. Only one transaction is ever outstanding.

Test Plan:
- Zero-wait slave, pulse start, VERIFY=1 -> writes to 0x0,0x4,0x8,0xC with A5A5A5A5, 5A5A5A5A, 12345678, CAFEF00D, each followed by a matching read; done=1, error=0, busy low in DONE.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID/AWADDR held stable 3 cycles; BREADY asserts only after both handshakes.
- BRESP=2'b10 on entry 2 -> done=1, error=1, err_code=01, err_index=2; no ARVALID for entry 2, no AWVALID for entry 3.
- Slave returns RDATA=32'h0BAD0BAD for entry 1 -> err_code=10, err_index=1, done=1.
- BVALID never asserted on entry 0 -> error exit after 255 waiting cycles with err_code=11, err_index=0, BREADY=0.
- ARESET pulsed mid WR_REQ of entry 1 -> all outputs at reset values immediately, no further traffic; new start reruns from entry 0 and completes clean. Start pulse while busy has no effect.
